// File: rtl/bsg_counter_dynamic_countdown.sv
// Loadable down-counter with valid/ready start handshake and a held done flag.
// A start value L takes L+1 enabled cycles to reach DONE, matching the up-counter period.
module bsg_counter_dynamic_countdown #(
    parameter int width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] limit_i,
    output logic               ready_o,
    input  logic               en_i,
    output logic [width_p-1:0] counter_o,
    output logic               busy_o,
    output logic               v_o,
    input  logic               yumi_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [width_p-1:0] count_q, count_d;

    // ready_o is combinational from yumi_i so a new load can replace an acknowledged done.
    assign ready_o   = (state_q == IDLE) | ((state_q == DONE) & yumi_i);
    assign busy_o    = (state_q == COUNT);
    assign v_o       = (state_q == DONE);
    assign counter_o = count_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (v_i) begin
                    state_d = COUNT;
                    count_d = limit_i;
                end
            end
            COUNT: begin
                // Zero costs one extra enabled cycle before DONE, so no decrement ever wraps.
                if (en_i) begin
                    if (count_q != '0) begin
                        count_d = count_q - width_p'(1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (yumi_i) begin
                    if (v_i) begin
                        state_d = COUNT;
                        count_d = limit_i;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_bsg_counter_dynamic_countdown.sv
// Self-checking bench for bsg_counter_dynamic_countdown: directed scenarios plus random
// traffic, compared every cycle against a "remaining enabled cycles" reference model.
module tb_bsg_counter_dynamic_countdown;

    localparam int W = 16;

    logic         clk_i = 1'b0;
    logic         reset_i, v_i, en_i, yumi_i;
    logic [W-1:0] limit_i;
    logic         ready_o, busy_o, v_o;
    logic [W-1:0] counter_o;

    int errors = 0;
    int checks = 0;

    // Reference model: a loaded value L owes L+1 enabled cycles; counter shows what is left minus one.
    bit     m_busy = 1'b0;
    bit     m_done = 1'b0;
    longint m_rem  = 0;

    always #5 clk_i = ~clk_i;

    bsg_counter_dynamic_countdown #(.width_p(W)) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .v_i      (v_i),
        .limit_i  (limit_i),
        .ready_o  (ready_o),
        .en_i     (en_i),
        .counter_o(counter_o),
        .busy_o   (busy_o),
        .v_o      (v_o),
        .yumi_i   (yumi_i)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Acknowledging outside DONE is illegal; the bench never intends it, so flag any occurrence.
    always @(posedge clk_i) begin
        if (!reset_i && yumi_i && !v_o) checkOutput("yumi_legal", {31'd0, v_o}, 32'd1);
    end

    function automatic logic [31:0] expCounter();
        return m_busy ? 32'(m_rem - 1) : 32'd0;
    endfunction

    function automatic bit expReady(input bit yumi);
        return !m_busy && (!m_done || yumi);
    endfunction

    task automatic applyStimulus(input bit rst, input bit v, input logic [W-1:0] lim,
                                 input bit en, input bit yumi);
        bit rdy;
        reset_i = rst;
        v_i     = v;
        limit_i = lim;
        en_i    = en;
        yumi_i  = yumi;
        #1;
        rdy = expReady(yumi);
        if (!rst) checkOutput("ready_o", {31'd0, ready_o}, {31'd0, rdy});
        @(posedge clk_i);
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_rem  = 0;
        end else if (v && rdy) begin
            m_busy = 1'b1;
            m_done = 1'b0;
            m_rem  = longint'(lim) + 1;
        end else if (m_done && yumi) begin
            m_done = 1'b0;
        end else if (m_busy && en) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
        #1;
        checkOutput("counter_o", {16'd0, counter_o}, expCounter());
        checkOutput("busy_o", {31'd0, busy_o}, {31'd0, m_busy});
        checkOutput("v_o", {31'd0, v_o}, {31'd0, m_done});
    endtask

    initial begin
        int  n;
        bit  pre_busy;
        bit  en_t;
        bit  acc;

        applyStimulus(1, 0, '0, 0, 0);
        applyStimulus(1, 0, '0, 0, 0);
        checkOutput("reset_ready", {31'd0, ready_o}, 32'd1);

        // Scenario 1: L=3, en held high; v_o appears on the 5th cycle after the load edge.
        applyStimulus(0, 1, 16'd3, 1, 0);
        checkOutput("t1_load", {16'd0, counter_o}, 32'd3);
        n = 1;
        while (!v_o && n < 20) begin
            applyStimulus(0, 0, '0, 1, 0);
            n++;
        end
        checkOutput("t1_latency", n, 32'd5);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, $urandom_range(0, 1), 0);
        checkOutput("t1_hold", {31'd0, v_o}, 32'd1);
        applyStimulus(0, 0, '0, 0, 1);

        // Scenario 2: L=0 finishes two cycles after load; L=max never wraps.
        applyStimulus(0, 1, 16'd0, 1, 0);
        applyStimulus(0, 0, '0, 1, 0);
        checkOutput("t2_zero_done", {31'd0, v_o}, 32'd1);
        applyStimulus(0, 0, '0, 0, 1);
        applyStimulus(0, 1, 16'hFFFF, 1, 0);
        n = 0;
        while (!v_o && n < 70000) begin
            pre_busy = busy_o;
            applyStimulus(0, 0, '0, 1, 0);
            if (pre_busy) n++;
        end
        checkOutput("t2_max_cycles", n, 32'd65536);
        applyStimulus(0, 0, '0, 0, 1);

        // Scenario 3: toggling enable; exactly 6 enabled cycles before done.
        applyStimulus(0, 1, 16'd5, 0, 0);
        n = 0;
        en_t = 1'b1;
        for (int i = 0; i < 40 && !v_o; i++) begin
            pre_busy = busy_o;
            applyStimulus(0, 0, '0, en_t, 0);
            if (pre_busy && en_t) n++;
            en_t = ~en_t;
        end
        checkOutput("t3_en_cycles", n, 32'd6);

        // Scenario 4: acknowledge and reload in the same cycle.
        applyStimulus(0, 1, 16'd7, 1, 1);
        checkOutput("t4_counter", {16'd0, counter_o}, 32'd7);
        checkOutput("t4_busy", {31'd0, busy_o}, 32'd1);

        // Scenario 5: a held request during COUNT waits for the done handshake.
        for (int i = 0; i < 8 && !v_o; i++) applyStimulus(0, 0, '0, 1, 0);
        applyStimulus(0, 0, '0, 0, 1);
        applyStimulus(0, 1, 16'd3, 1, 0);
        for (int i = 0; i < 20; i++) begin
            acc = m_done;
            applyStimulus(0, 1, 16'd9, 1, m_done);
            if (acc) break;
        end
        checkOutput("t5_load", {16'd0, counter_o}, 32'd9);

        // Scenario 6: reset mid-count at 4, then reset while in DONE.
        applyStimulus(1, 0, '0, 0, 0);
        applyStimulus(0, 1, 16'd6, 1, 0);
        applyStimulus(0, 0, '0, 1, 0);
        applyStimulus(0, 0, '0, 1, 0);
        checkOutput("t6_mid", {16'd0, counter_o}, 32'd4);
        applyStimulus(1, 0, '0, 1, 0);
        checkOutput("t6_ready", {31'd0, ready_o}, 32'd1);
        applyStimulus(0, 1, 16'd0, 1, 0);
        applyStimulus(0, 0, '0, 1, 0);
        checkOutput("t6_done", {31'd0, v_o}, 32'd1);
        applyStimulus(1, 0, '0, 0, 0);
        checkOutput("t6_ready2", {31'd0, ready_o}, 32'd1);

        // Random traffic with occasional resets and legal acknowledges only.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 99) == 0, ($urandom % 3) == 0,
                          W'($urandom_range(0, 12)), ($urandom % 4) != 0,
                          m_done && ($urandom % 2 == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
